or_8way: RTL and testbench

- Registered 8-input OR reduction over eight independent single-bit inputs a..h.
- Besides the OR result y, it reports the lowest-index asserted input and the number of asserted inputs.
- It is a general-purpose leaf gate used as an "any request / any flag" detector in larger datapaths.

---
 rtl/or_8way_pkg.sv | 10 +
 rtl/or_8way_popcount.sv | 16 +
 rtl/or_8way.sv | 83 ++++++++
 tb/tb_or_8way.sv | 125 ++++++++++++
 4 files changed

// File: rtl/or_8way_pkg.sv
// rtl/or_8way_pkg.sv - shared widths and vector types for the 8-way OR reduction
package or_8way_pkg;
    localparam int N_IN  = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef logic [N_IN-1:0]  in_vec_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/or_8way_popcount.sv
// rtl/or_8way_popcount.sv - combinational population count of the 8-bit input vector
module or_8way_popcount
    import or_8way_pkg::*;
(
    input  in_vec_t v,
    output cnt_t    cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N_IN; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
    end

endmodule

// File: rtl/or_8way.sv
// rtl/or_8way.sv - registered 8-input OR with lowest-index and count; OR8WAY_STICKY_EN adds clr/sticky
module or_8way
    import or_8way_pkg::*;
#(
    parameter int PIPE_OUT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    input  logic g,
    input  logic h,
`ifdef OR8WAY_STICKY_EN
    input  logic clr,
`endif
    output logic y,
    output idx_t idx,
    output cnt_t cnt
`ifdef OR8WAY_STICKY_EN
    ,
    output logic sticky
`endif
);

    in_vec_t v;
    logic    y_n;
    idx_t    idx_n;
    cnt_t    cnt_n;

    assign v   = {h, g, f, e, d, c, b, a};
    assign y_n = |v;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_n = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx_n = IDX_W'(i);
            end
        end
    end

    or_8way_popcount u_popcount (
        .v   (v),
        .cnt (cnt_n)
    );

    generate
        if (PIPE_OUT != 0) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    y   <= 1'b0;
                    idx <= '0;
                    cnt <= '0;
                end else begin
                    y   <= y_n;
                    idx <= idx_n;
                    cnt <= cnt_n;
                end
            end
        end else begin : g_comb
            assign y   = y_n;
            assign idx = idx_n;
            assign cnt = cnt_n;
        end
    endgenerate

`ifdef OR8WAY_STICKY_EN
    // Clear takes priority over a same-edge set.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sticky <= 1'b0;
        end else if (y_n) begin
            sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_or_8way.sv
// tb/tb_or_8way.sv - randomized and directed checks of or_8way in registered and combinational builds
module tb_or_8way;
    import or_8way_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 0, b = 0, c = 0, d = 0, e = 0, f = 0, g = 0, h = 0;
    logic y_p, y_c;
    idx_t idx_p, idx_c;
    cnt_t cnt_p, cnt_c;
`ifdef OR8WAY_STICKY_EN
    logic clr = 1'b0;
    logic sticky_p, sticky_c;
    logic sticky_exp = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_y, exp_idx, exp_cnt;

    always #5 clk = ~clk;

    or_8way #(.PIPE_OUT(1)) u_pipe (
        .clk(clk), .rst(rst),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
`ifdef OR8WAY_STICKY_EN
        .clr(clr), .sticky(sticky_p),
`endif
        .y(y_p), .idx(idx_p), .cnt(cnt_p)
    );

    or_8way #(.PIPE_OUT(0)) u_comb (
        .clk(clk), .rst(rst),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
`ifdef OR8WAY_STICKY_EN
        .clr(clr), .sticky(sticky_c),
`endif
        .y(y_c), .idx(idx_c), .cnt(cnt_c)
    );

    function automatic logic [7:0] ref_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 8'(i);
        end
        return 8'd0;
    endfunction

    function automatic logic [7:0] ref_cnt(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) n++;
        end
        return 8'(n);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input logic [7:0] nv, input logic nr, input logic nclr);
        {h, g, f, e, d, c, b, a} = nv;
        rst = nr;
`ifdef OR8WAY_STICKY_EN
        clr = nclr;
`endif
        #1;
        chk("comb_y",   8'(y_c),   (nv != 0) ? 8'd1 : 8'd0);
        chk("comb_idx", 8'(idx_c), ref_idx(nv));
        chk("comb_cnt", 8'(cnt_c), ref_cnt(nv));
        @(posedge clk);
        if (nr) begin
            exp_y = 0; exp_idx = 0; exp_cnt = 0;
        end else begin
            exp_y = (nv != 0) ? 8'd1 : 8'd0;
            exp_idx = ref_idx(nv);
            exp_cnt = ref_cnt(nv);
        end
`ifdef OR8WAY_STICKY_EN
        if (nr || nclr) sticky_exp = 1'b0;
        else if (nv != 0) sticky_exp = 1'b1;
`endif
        #1;
        chk("pipe_y",   8'(y_p),   exp_y);
        chk("pipe_idx", 8'(idx_p), exp_idx);
        chk("pipe_cnt", 8'(cnt_p), exp_cnt);
`ifdef OR8WAY_STICKY_EN
        chk("sticky_p", 8'(sticky_p), 8'(sticky_exp));
        chk("sticky_c", 8'(sticky_c), 8'(sticky_exp));
`else
        if (nclr) total = total + 0;
`endif
    endtask

    initial begin
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(8'(1 << i), 1'b0, 1'b0);
        end
        step(8'h00, 1'b0, 1'b0);
        step(8'hFF, 1'b0, 1'b0);
        step(8'hA4, 1'b0, 1'b0);
        step(8'hA4, 1'b1, 1'b0);
        step(8'h80, 1'b0, 1'b0);
`ifdef OR8WAY_STICKY_EN
        step(8'h00, 1'b1, 1'b0);
        step(8'h10, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h08, 1'b0, 1'b1);
        step(8'h08, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 60; i++) begin
            step(8'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
